// File: rtl/conv_apb_pkg.sv
// Shared definitions for the convolution accelerator APB initiator.
// State encodings and accelerator register offsets.
package conv_apb_pkg;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SETUP  = 3'd1;
    localparam logic [2:0] S_ACCESS = 3'd2;
    localparam logic [2:0] S_GAP    = 3'd3;
    localparam logic [2:0] S_RESP   = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE   = S_IDLE,
        ST_SETUP  = S_SETUP,
        ST_ACCESS = S_ACCESS,
        ST_GAP    = S_GAP,
        ST_RESP   = S_RESP
    } apb_state_t;

    localparam logic [31:0] REG_CMD     = 32'h0000_0000;
    localparam logic [31:0] REG_INCH    = 32'h0000_0004;
    localparam logic [31:0] REG_OUTCH   = 32'h0000_0008;
    localparam logic [31:0] REG_FLENGTH = 32'h0000_000C;
    localparam logic [31:0] REG_FLAGS   = 32'h0000_0010;

endpackage

// File: rtl/conv_apb_master.sv
// APB initiator driving the convolution accelerator register slave.
// Single outstanding write, read or poll-until-match command.
module conv_apb_master
    import conv_apb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int POLL_CNT_W = 16
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic                  cmd_poll,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    input  logic [DATA_WIDTH-1:0] cmd_mask,
    input  logic [POLL_CNT_W-1:0] poll_limit,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR
);

    localparam logic [POLL_CNT_W-1:0] CNT_MAX = {POLL_CNT_W{1'b1}};

    apb_state_t state_q, state_d;

    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic [DATA_WIDTH-1:0] cmp_q, cmp_d;
    logic [DATA_WIDTH-1:0] mask_q, mask_d;
    logic                  write_q, write_d;
    logic                  poll_q, poll_d;
    logic [POLL_CNT_W-1:0] limit_q, limit_d;
    logic [POLL_CNT_W-1:0] cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;
    logic                  tmo_q, tmo_d;
    logic                  psel_q, psel_d;
    logic                  pen_q, pen_d;
    logic                  crdy_q, crdy_d;
    logic                  rval_q, rval_d;

    logic [POLL_CNT_W-1:0] cnt_inc;
    logic                  hit;

    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    assign hit     = ((PRDATA & mask_q) == (cmp_q & mask_q));

    // Next-state, command latch, poll bookkeeping and registered outputs
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        pwdata_d = pwdata_q;
        cmp_d    = cmp_q;
        mask_d   = mask_q;
        write_d  = write_q;
        poll_d   = poll_q;
        limit_d  = limit_q;
        cnt_d    = cnt_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        tmo_d    = tmo_q;

        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid && crdy_q) begin
                    addr_d   = cmd_addr;
                    write_d  = cmd_write & ~cmd_poll;
                    pwdata_d = (cmd_write && !cmd_poll) ? cmd_wdata : '0;
                    cmp_d    = cmd_wdata;
                    mask_d   = cmd_mask;
                    poll_d   = cmd_poll;
                    limit_d  = poll_limit;
                    cnt_d    = '0;
                    rdata_d  = '0;
                    err_d    = 1'b0;
                    tmo_d    = 1'b0;
                    state_d  = ST_SETUP;
                end
            end
            ST_SETUP: state_d = ST_ACCESS;
            ST_ACCESS: begin
                if (PREADY) begin
                    cnt_d = cnt_inc;
                    err_d = PSLVERR;
                    if (!write_q) rdata_d = PRDATA;
                    if (!poll_q || hit || PSLVERR) begin
                        state_d = ST_RESP;
                    end else if (limit_q != '0 && cnt_inc == limit_q) begin
                        tmo_d   = 1'b1;
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_GAP;
                    end
                end
            end
            ST_GAP:  state_d = ST_SETUP;
            ST_RESP: begin
                if (rval_q && rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        crdy_d = (state_d == ST_IDLE);
        psel_d = (state_d == ST_SETUP) || (state_d == ST_ACCESS);
        pen_d  = (state_d == ST_ACCESS);
        rval_d = (state_d == ST_RESP);
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            pwdata_q <= '0;
            cmp_q    <= '0;
            mask_q   <= '0;
            write_q  <= 1'b0;
            poll_q   <= 1'b0;
            limit_q  <= '0;
            cnt_q    <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            tmo_q    <= 1'b0;
            psel_q   <= 1'b0;
            pen_q    <= 1'b0;
            crdy_q   <= 1'b0;
            rval_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            pwdata_q <= pwdata_d;
            cmp_q    <= cmp_d;
            mask_q   <= mask_d;
            write_q  <= write_d;
            poll_q   <= poll_d;
            limit_q  <= limit_d;
            cnt_q    <= cnt_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            tmo_q    <= tmo_d;
            psel_q   <= psel_d;
            pen_q    <= pen_d;
            crdy_q   <= crdy_d;
            rval_q   <= rval_d;
        end
    end

    assign cmd_ready   = crdy_q;
    assign rsp_valid   = rval_q;
    assign rsp_rdata   = rdata_q;
    assign rsp_err     = err_q;
    assign rsp_timeout = tmo_q;
    assign PADDR       = addr_q;
    assign PSEL        = psel_q;
    assign PENABLE     = pen_q;
    assign PWRITE      = write_q;
    assign PWDATA      = pwdata_q;

endmodule

// File: tb/tb_conv_apb_master.sv
// Directed bench for conv_apb_master with a small APB slave model.
// Outputs are sampled and inputs driven on the falling edge.
module tb_conv_apb_master;
    import conv_apb_pkg::*;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        cmd_valid, cmd_ready, cmd_write, cmd_poll;
    logic [31:0] cmd_addr, cmd_wdata, cmd_mask;
    logic [15:0] poll_limit;
    logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic [31:0] PADDR, PWDATA, PRDATA;
    logic        PSEL, PENABLE, PWRITE, PREADY, PSLVERR;

    int n_tests = 0;
    int n_fail  = 0;

    int          ws_cfg  = 0;
    logic        err_cfg = 1'b0;
    logic [31:0] rdv [8];
    int          base    = 0;
    int          wcnt    = 0;
    int          n_xfer  = 0;

    always #5 CLK = ~CLK;

    conv_apb_master dut (
        .CLK(CLK), .RESET(RESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_write(cmd_write), .cmd_poll(cmd_poll),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .cmd_mask(cmd_mask), .poll_limit(poll_limit),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .rsp_timeout(rsp_timeout),
        .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA),
        .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    // Slave model: programmable wait states, scripted read data
    always @(posedge CLK) begin
        if (PSEL && !PENABLE) wcnt <= 0;
        else if (PSEL && PENABLE) wcnt <= wcnt + 1;
        if (PSEL && PENABLE && PREADY) n_xfer <= n_xfer + 1;
    end

    assign PREADY  = PSEL && PENABLE && (wcnt >= ws_cfg);
    assign PSLVERR = err_cfg && PREADY;

    always_comb begin
        int k;
        k = n_xfer - base;
        if (k > 7) k = 7;
        if (k < 0) k = 0;
        PRDATA = rdv[k];
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic set_rdv(input logic [31:0] a, b, c);
        for (int i = 0; i < 8; i++) rdv[i] = 32'h0;
        rdv[0] = a;
        rdv[1] = b;
        rdv[2] = c;
        base = n_xfer;
    endtask

    task automatic issue(input logic w, p, input logic [31:0] a, d, m,
                         input logic [15:0] lim);
        int i;
        i = 0;
        while (!cmd_ready && i < 50) begin
            @(negedge CLK);
            i++;
        end
        if (!cmd_ready) chk("cmd_ready_wait", {31'b0, cmd_ready}, 32'd1);
        cmd_valid  = 1'b1;
        cmd_write  = w;
        cmd_poll   = p;
        cmd_addr   = a;
        cmd_wdata  = d;
        cmd_mask   = m;
        poll_limit = lim;
        @(negedge CLK);
        cmd_valid = 1'b0;
    endtask

    task automatic run_to_rsp(input logic [31:0] exp_addr,
                              output int cyc, acc, gaps,
                              output logic bad);
        cyc  = 0;
        acc  = 0;
        gaps = 0;
        bad  = 1'b0;
        for (int i = 1; i <= 300; i++) begin
            @(negedge CLK);
            if (rsp_valid) begin
                cyc = i;
                break;
            end
            if (PSEL && PENABLE) acc++;
            if (!PSEL) gaps++;
            if (PSEL && PADDR !== exp_addr) bad = 1'b1;
        end
        if (!rsp_valid) chk("rsp_wait", {31'b0, rsp_valid}, 32'd1);
    endtask

    task automatic handshake();
        rsp_ready = 1'b1;
        @(negedge CLK);
        rsp_ready = 1'b0;
        chk("hs_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("hs_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    endtask

    initial begin
        int cyc, acc, gaps, x0;
        logic bad;

        RESET = 1'b1;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_poll = 1'b0;
        cmd_addr = '0; cmd_wdata = '0; cmd_mask = '0;
        poll_limit = '0; rsp_ready = 1'b0;
        set_rdv(0, 0, 0);

        repeat (3) @(negedge CLK);
        chk("rst_cmd_ready", {31'b0, cmd_ready}, 32'd0);
        chk("rst_psel", {31'b0, PSEL}, 32'd0);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst_paddr", PADDR, 32'd0);
        RESET = 1'b0;
        @(negedge CLK);
        chk("post_rst_ready", {31'b0, cmd_ready}, 32'd1);

        // Write, zero wait states: exact cycle-by-cycle timing
        issue(1'b1, 1'b0, REG_CMD, 32'h1, 32'h0, 16'd0);
        chk("w_setup_psel", {31'b0, PSEL}, 32'd1);
        chk("w_setup_pen", {31'b0, PENABLE}, 32'd0);
        chk("w_setup_ready", {31'b0, cmd_ready}, 32'd0);
        @(negedge CLK);
        chk("w_acc_pen", {31'b0, PENABLE}, 32'd1);
        chk("w_acc_pwrite", {31'b0, PWRITE}, 32'd1);
        chk("w_acc_pwdata", PWDATA, 32'h1);
        chk("w_acc_paddr", PADDR, REG_CMD);
        @(negedge CLK);
        chk("w_rsp_valid", {31'b0, rsp_valid}, 32'd1);
        chk("w_rsp_psel", {31'b0, PSEL}, 32'd0);
        chk("w_rsp_err", {31'b0, rsp_err}, 32'd0);
        chk("w_rsp_rdata", rsp_rdata, 32'h0);
        handshake();

        // Read with 3 wait states
        ws_cfg = 3;
        set_rdv(32'h40, 0, 0);
        issue(1'b0, 1'b0, REG_INCH, 32'hDEAD_BEEF, 32'h0, 16'd0);
        run_to_rsp(REG_INCH, cyc, acc, gaps, bad);
        chk("r_acc_cycles", acc, 32'd4);
        chk("r_paddr_stable", {31'b0, bad}, 32'd0);
        chk("r_rdata", rsp_rdata, 32'h40);
        chk("r_pwdata_zero", PWDATA, 32'h0);
        chk("r_pwrite", {31'b0, PWRITE}, 32'd0);
        handshake();

        // Poll until bit0 set, unlimited
        ws_cfg = 0;
        set_rdv(32'h0, 32'h0, 32'h1);
        x0 = n_xfer;
        issue(1'b0, 1'b1, REG_FLAGS, 32'h1, 32'h1, 16'd0);
        run_to_rsp(REG_FLAGS, cyc, acc, gaps, bad);
        chk("p_latency", cyc, 32'd8);
        chk("p_reads", n_xfer - x0, 32'd3);
        chk("p_gaps", gaps, 32'd2);
        chk("p_timeout", {31'b0, rsp_timeout}, 32'd0);
        chk("p_rdata", rsp_rdata, 32'h1);
        handshake();

        // Poll with limit 4, never matches
        set_rdv(0, 0, 0);
        x0 = n_xfer;
        issue(1'b0, 1'b1, REG_FLAGS, 32'h1, 32'h1, 16'd4);
        run_to_rsp(REG_FLAGS, cyc, acc, gaps, bad);
        chk("pl_reads", n_xfer - x0, 32'd4);
        chk("pl_latency", cyc, 32'd11);
        chk("pl_timeout", {31'b0, rsp_timeout}, 32'd1);
        chk("pl_err", {31'b0, rsp_err}, 32'd0);
        handshake();

        // Match on the same read the limit is reached
        set_rdv(32'h0, 32'h3, 0);
        x0 = n_xfer;
        issue(1'b0, 1'b1, REG_FLAGS, 32'h2, 32'h2, 16'd2);
        run_to_rsp(REG_FLAGS, cyc, acc, gaps, bad);
        chk("pm_reads", n_xfer - x0, 32'd2);
        chk("pm_timeout", {31'b0, rsp_timeout}, 32'd0);
        chk("pm_rdata", rsp_rdata, 32'h3);
        handshake();

        // Slave error during a poll ends it at once
        err_cfg = 1'b1;
        set_rdv(0, 0, 0);
        x0 = n_xfer;
        issue(1'b0, 1'b1, REG_FLAGS, 32'h1, 32'h1, 16'd0);
        run_to_rsp(REG_FLAGS, cyc, acc, gaps, bad);
        chk("pe_reads", n_xfer - x0, 32'd1);
        chk("pe_err", {31'b0, rsp_err}, 32'd1);
        chk("pe_timeout", {31'b0, rsp_timeout}, 32'd0);
        handshake();

        // Write error with response backpressure and a stray command
        issue(1'b1, 1'b0, REG_OUTCH, 32'h5, 32'h0, 16'd0);
        run_to_rsp(REG_OUTCH, cyc, acc, gaps, bad);
        err_cfg = 1'b0;
        chk("we_err", {31'b0, rsp_err}, 32'd1);
        bad = 1'b0;
        cmd_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            if (!rsp_valid || !rsp_err || rsp_timeout || cmd_ready ||
                PSEL || rsp_rdata !== 32'h0)
                bad = 1'b1;
        end
        cmd_valid = 1'b0;
        chk("we_hold_stable", {31'b0, bad}, 32'd0);
        handshake();

        // Reset during an ACCESS wait state
        ws_cfg = 10;
        issue(1'b0, 1'b0, REG_FLENGTH, 32'h0, 32'h0, 16'd0);
        @(negedge CLK);
        @(negedge CLK);
        chk("ra_in_access", {31'b0, PENABLE}, 32'd1);
        RESET = 1'b1;
        @(negedge CLK);
        chk("ra_psel", {31'b0, PSEL}, 32'd0);
        chk("ra_pen", {31'b0, PENABLE}, 32'd0);
        chk("ra_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        RESET = 1'b0;
        @(negedge CLK);
        chk("ra_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        chk("ra_no_rsp", {31'b0, rsp_valid}, 32'd0);
        ws_cfg = 0;
        issue(1'b1, 1'b0, REG_CMD, 32'h2, 32'h0, 16'd0);
        run_to_rsp(REG_CMD, cyc, acc, gaps, bad);
        chk("ra_new_latency", cyc, 32'd2);
        chk("ra_new_err", {31'b0, rsp_err}, 32'd0);
        handshake();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
